// File: rtl/alu_arbiter_ctrl.sv
// alu_arbiter_ctrl: shares one ALU between two requesters and returns tagged responses.
// Define ALU_ARB_FIXED_PRIO_EN to make req0 always win ties (req1 may starve); default is round robin.
module alu_arbiter_ctrl #(
    parameter int WIDTH     = 32,
    parameter int SHORT_LAT = 1,
    parameter int LONG_LAT  = 3
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [2:0]       i_req0_op,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_b,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [2:0]       i_req1_op,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_b,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [2:0]       o_alu_ctrl,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic [WIDTH-1:0] i_alu_result2,
    input  logic [3:0]       i_alu_flags,
    output logic             o_resp_valid,
    input  logic             i_resp_ready,
    output logic             o_resp_id,
    output logic [WIDTH-1:0] o_resp_result,
    output logic [WIDTH-1:0] o_resp_result2,
    output logic [3:0]       o_resp_flags,
    output logic             o_resp_err,
    output logic             o_busy
);
    localparam int MAX_LAT = (LONG_LAT > SHORT_LAT) ? LONG_LAT : SHORT_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_alu_a, r_alu_b, r_result, r_result2;
    logic [2:0]       r_alu_ctrl;
    logic [3:0]       r_flags;
    logic             r_resp_id, r_err;
    logic             w_gnt_valid, w_gnt_id, w_accept, w_done, w_illegal, w_wide;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_a, w_b;

    assign w_gnt_valid = i_req0_valid | i_req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_gnt_id = ~i_req0_valid;
`else
    assign w_gnt_id = (i_req0_valid & i_req1_valid) ? ~r_last_grant : i_req1_valid;
`endif
    assign w_op      = w_gnt_id ? i_req1_op : i_req0_op;
    assign w_a       = w_gnt_id ? i_req1_a : i_req0_a;
    assign w_b       = w_gnt_id ? i_req1_b : i_req0_b;
    assign w_illegal = (w_op == 3'b111);
    // only the 64-bit multiplies produce a meaningful high word
    assign w_wide    = (r_alu_ctrl == 3'b101) | (r_alu_ctrl == 3'b110);

    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept     = w_gnt_valid;
                o_req0_ready = w_gnt_valid & ~w_gnt_id;
                o_req1_ready = w_gnt_valid & w_gnt_id;
                if (w_gnt_valid) w_next = w_illegal ? RESP : EXEC;
            end
            EXEC: begin
                w_done = (r_cnt == '0);
                if (w_done) w_next = RESP;
            end
            RESP:    w_next = i_resp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_state <= IDLE;
        else            r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_ctrl   <= '0;
            r_result     <= '0;
            r_result2    <= '0;
            r_flags      <= '0;
            r_resp_id    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_resp_id    <= w_gnt_id;
                r_last_grant <= w_gnt_id;
                r_cnt        <= w_op[2] ? CW'(LONG_LAT - 1) : CW'(SHORT_LAT - 1);
                r_err        <= w_illegal;
                if (w_illegal) begin
                    r_result  <= '0;
                    r_result2 <= '0;
                    r_flags   <= '0;
                end else begin
                    r_alu_ctrl <= w_op;
                    r_alu_a    <= w_a;
                    r_alu_b    <= w_b;
                end
            end
            if (r_state == EXEC) begin
                r_cnt <= r_cnt - CW'(1);
                if (w_done) begin
                    r_result  <= i_alu_result;
                    r_result2 <= w_wide ? i_alu_result2 : '0;
                    r_flags   <= i_alu_flags;
                end
            end
        end
    end

    assign o_alu_a        = r_alu_a;
    assign o_alu_b        = r_alu_b;
    assign o_alu_ctrl     = r_alu_ctrl;
    assign o_resp_valid   = (r_state == RESP);
    assign o_resp_id      = r_resp_id;
    assign o_resp_result  = r_result;
    assign o_resp_result2 = r_result2;
    assign o_resp_flags   = r_flags;
    assign o_resp_err     = r_err;
    assign o_busy         = (r_state != IDLE);
endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// tb_alu_arbiter_ctrl: vector table, corner sequences and randomized traffic against a reference model.
// Honours ALU_ARB_FIXED_PRIO_EN for arbitration expectations.
module tb_alu_arbiter_ctrl;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] r2;
        logic [3:0]  f;
    } alu_out_t;

    typedef struct {
        logic        id;
        logic [2:0]  op;
        logic [31:0] a, b, r, r2;
        logic [3:0]  f;
        logic        e;
        int          lat;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        v0 = 0, v1 = 0, rdy0, rdy1, resp_ready = 0;
    logic [2:0]  op0 = 0, op1 = 0, alu_ctrl;
    logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0, alu_a, alu_b;
    logic        resp_valid, resp_id, resp_err, busy;
    logic [31:0] resp_result, resp_result2;
    logic [3:0]  resp_flags;
    alu_out_t    alu_o;
    int          n_chk = 0, n_pass = 0, cyc = 0;
    bit          m_last = 1'b1;

    always #5 clk = ~clk;

    // External ALU model: non-multiply ops drive a garbage high word the DUT must mask.
    function automatic alu_out_t alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_out_t    o;
        logic [32:0] s;
        logic [63:0] p;
        o    = '0;
        o.r2 = ~a;
        s    = '0;
        p    = '0;
        case (op)
            3'b000: begin
                s   = {1'b0, a} + {1'b0, b};
                o.r = s[31:0];
                o.f = {s[31], s[31:0] == 32'd0, s[32], (a[31] == b[31]) && (s[31] != a[31])};
            end
            3'b001: begin
                s   = {1'b0, a} + {1'b0, ~b} + 33'd1;
                o.r = s[31:0];
                o.f = {s[31], s[31:0] == 32'd0, s[32], (a[31] != b[31]) && (s[31] != a[31])};
            end
            3'b010: begin o.r = a & b; o.f = {o.r[31], o.r == 32'd0, 2'b00}; end
            3'b011: begin o.r = a | b; o.f = {o.r[31], o.r == 32'd0, 2'b00}; end
            3'b100: begin o.r = a * b; o.f = {o.r[31], o.r == 32'd0, 2'b00}; end
            3'b101: begin
                p = {32'd0, a} * {32'd0, b};
                o.r = p[31:0]; o.r2 = p[63:32]; o.f = {p[63], p == 64'd0, 2'b00};
            end
            3'b110: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                o.r = p[31:0]; o.r2 = p[63:32]; o.f = {p[63], p == 64'd0, 2'b00};
            end
            default: begin o.r = a ^ b; o.f = 4'hF; end
        endcase
        return o;
    endfunction

    function automatic alu_out_t expect_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_out_t o;
        o = alu_f(op, a, b);
        if (op == 3'b111) o = '0;
        else if (op != 3'b101 && op != 3'b110) o.r2 = '0;
        return o;
    endfunction

    function automatic int lat_f(input logic [2:0] op);
        return (op == 3'b111) ? 0 : (op[2] ? 3 : 1);
    endfunction

    assign alu_o = alu_f(alu_ctrl, alu_a, alu_b);

    alu_arbiter_ctrl dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req0_valid(v0), .o_req0_ready(rdy0), .i_req0_op(op0), .i_req0_a(a0), .i_req0_b(b0),
        .i_req1_valid(v1), .o_req1_ready(rdy1), .i_req1_op(op1), .i_req1_a(a1), .i_req1_b(b1),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_ctrl(alu_ctrl),
        .i_alu_result(alu_o.r), .i_alu_result2(alu_o.r2), .i_alu_flags(alu_o.f),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_id(resp_id),
        .o_resp_result(resp_result), .o_resp_result2(resp_result2), .o_resp_flags(resp_flags),
        .o_resp_err(resp_err), .o_busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 0; v0 = 0; v1 = 0; resp_ready = 0;
        tick();
        tick();
        rst_n  = 1;
        m_last = 1'b1;
    endtask

    task automatic set_req(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id) begin v1 = 1; op1 = op; a1 = a; b1 = b; end
        else    begin v0 = 1; op0 = op; a0 = a; b0 = b; end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 30) begin tick(); n++; end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic run_op(input vec_t t);
        int n;
        set_req(t.id, t.op, t.a, t.b);
        #1;
        chk("vec_ready", t.id ? rdy1 : rdy0, 1);
        tick();
        v0 = 0; v1 = 0;
        n = 0;
        while (!resp_valid && n < 10) begin tick(); n++; end
        chk("vec_latency", n, t.lat);
        chk("vec_id", resp_id, t.id);
        chk("vec_result", resp_result, t.r);
        chk("vec_result2", resp_result2, t.r2);
        chk("vec_flags", resp_flags, t.f);
        chk("vec_err", resp_err, t.e);
        resp_ready = 1;
        tick();
        resp_ready = 0;
        chk("vec_resp_drop", resp_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[12];
        int          n, got, done;
        bit          pend, seen, acc, gid, exp_id;
        int          acc_cyc;
        logic [2:0]  pend_op;
        logic        pend_id;
        alu_out_t    pend_exp;
        logic [31:0] s_r;

        tbl[0]  = '{1'b0, 3'b000, 32'd5,          32'd3,          32'd8,          32'd0,          4'b0000, 1'b0, 1};
        tbl[1]  = '{1'b1, 3'b001, 32'd3,          32'd5,          32'hFFFFFFFE,   32'd0,          4'b1000, 1'b0, 1};
        tbl[2]  = '{1'b0, 3'b010, 32'hF0F000FF,   32'h0F0F00F0,   32'h000000F0,   32'd0,          4'b0000, 1'b0, 1};
        tbl[3]  = '{1'b1, 3'b011, 32'h80000000,   32'd1,          32'h80000001,   32'd0,          4'b1000, 1'b0, 1};
        tbl[4]  = '{1'b0, 3'b000, 32'h7FFFFFFF,   32'd1,          32'h80000000,   32'd0,          4'b1001, 1'b0, 1};
        tbl[5]  = '{1'b1, 3'b000, 32'hFFFFFFFF,   32'd1,          32'd0,          32'd0,          4'b0110, 1'b0, 1};
        tbl[6]  = '{1'b0, 3'b001, 32'd5,          32'd5,          32'd0,          32'd0,          4'b0110, 1'b0, 1};
        tbl[7]  = '{1'b1, 3'b100, 32'd7,          32'd6,          32'd42,         32'd0,          4'b0000, 1'b0, 3};
        tbl[8]  = '{1'b0, 3'b101, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE,   32'd1,          4'b0000, 1'b0, 3};
        tbl[9]  = '{1'b1, 3'b110, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE,   32'hFFFFFFFF,   4'b1000, 1'b0, 3};
        tbl[10] = '{1'b0, 3'b111, 32'h12345678,   32'h9ABCDEF0,   32'd0,          32'd0,          4'b0000, 1'b1, 0};
        tbl[11] = '{1'b1, 3'b001, 32'h80000000,   32'd1,          32'h7FFFFFFF,   32'd0,          4'b0011, 1'b0, 1};

        rst_n = 0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_ready", {rdy0, rdy1}, 0);
        chk("rst_alu", {alu_a, alu_b, alu_ctrl}, 0);
        chk("rst_resp", {resp_id, resp_result, resp_err, resp_flags}, 0);
        rst_n = 1;
        tick();

        for (int i = 0; i < 12; i++) run_op(tbl[i]);

        // Both requesters stay valid: grants alternate, or req0 always wins under fixed priority.
        do_reset();
        set_req(0, 3'b010, 32'hFF, 32'h0F);
        set_req(1, 3'b010, 32'hF0, 32'h3C);
        resp_ready = 1;
        got = 0; n = 0;
        while (got < 4 && n < 40) begin
            #1;
            if (rdy0 && rdy1) chk("rr_dual_ready", 1, 0);
            if (rdy0 || rdy1) begin
                chk($sformatf("rr_grant%0d", got), rdy1, FIXED ? 0 : (got % 2));
                got++;
            end
            tick();
            n++;
        end
        chk("rr_count", got, 4);
        v0 = 0; v1 = 0;
        wait_idle();
        resp_ready = 0;

        // UMULL: ALU inputs held steady through EXEC, response at T+4.
        set_req(0, 3'b101, 32'hFFFFFFFF, 32'd2);
        #1;
        chk("umull_ready", rdy0, 1);
        tick();
        v0 = 0;
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("umull_hold_t%0d", k), {alu_a, alu_b, alu_ctrl}, {32'hFFFFFFFF, 32'd2, 3'b101});
            chk($sformatf("umull_busy_t%0d", k), {busy, resp_valid}, 2'b10);
            tick();
        end
        chk("umull_valid_t4", resp_valid, 1);
        chk("umull_res", {resp_result, resp_result2}, {32'hFFFFFFFE, 32'h00000001});
        resp_ready = 1;
        tick();
        resp_ready = 0;

        // Illegal op under backpressure: alu_ctrl untouched, response frozen, no grants.
        set_req(1, 3'b111, 32'hDEAD, 32'hBEEF);
        #1;
        chk("ill_ready", rdy1, 1);
        tick();
        v1 = 0;
        set_req(0, 3'b000, 32'd5, 32'd3);
        set_req(1, 3'b000, 32'd1, 32'd1);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp_ready_c%0d", k), {rdy0, rdy1}, 0);
            chk($sformatf("bp_resp_c%0d", k), {resp_valid, resp_err, resp_id, resp_result, resp_result2, resp_flags}, {3'b111, 68'd0});
            chk($sformatf("bp_alu_ctrl_c%0d", k), alu_ctrl, 3'b101);
            tick();
        end
        resp_ready = 1;
        #1;
        chk("retire_no_accept", {rdy0, rdy1}, 0);
        tick();
        resp_ready = 0;
        #1;
        chk("post_retire_grant", {rdy0, rdy1}, 2'b10);
        tick();
        v0 = 0;
        resp_ready = 1;
        n = 0;
        while (!rdy1 && n < 20) begin tick(); n++; end
        chk("req1_served", rdy1, 1);
        tick();
        v1 = 0;
        wait_idle();
        resp_ready = 0;

        // Reset during UMULL EXEC discards the op.
        set_req(0, 3'b101, 32'd9, 32'd9);
        #1;
        tick();
        v0 = 0;
        tick();
        rst_n = 0;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", resp_valid, 0);
        rst_n = 1;
        m_last = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("mid_rst_no_resp", {resp_valid, busy}, 0);

        // Randomized traffic against the reference model.
        pend = 0; seen = 0; done = 0; n = 0; acc_cyc = 0;
        pend_op = 0; pend_id = 0; pend_exp = '0;
        while (done < 60 && n < 3000) begin
            if (!v0 && $urandom_range(0, 1) == 1) set_req(0, 3'($urandom_range(0, 7)), $urandom, $urandom);
            if (!v1 && $urandom_range(0, 1) == 1) set_req(1, 3'($urandom_range(0, 7)), $urandom, $urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = rdy0 | rdy1;
            gid = rdy1;
            if (rdy0 && rdy1) chk("rand_dual_ready", 1, 0);
            if (acc) begin
                exp_id = (v0 && v1) ? (FIXED ? 1'b0 : ~m_last) : v1;
                chk("rand_grant", gid, exp_id);
                if (pend) chk("rand_overlap", 1, 0);
                pend     = 1;
                seen     = 0;
                acc_cyc  = cyc;
                pend_id  = gid;
                pend_op  = gid ? op1 : op0;
                pend_exp = gid ? expect_f(op1, a1, b1) : expect_f(op0, a0, b0);
                m_last   = gid;
            end
            if (resp_valid) begin
                if (!pend) chk("rand_spurious_resp", 1, 0);
                else begin
                    if (!seen) begin
                        chk("rand_latency", cyc - acc_cyc, lat_f(pend_op) + 1);
                        seen = 1;
                        s_r  = resp_result;
                    end
                    chk("rand_stable", resp_result, s_r);
                    if (resp_ready) begin
                        chk("rand_id", resp_id, pend_id);
                        chk("rand_result", {resp_result, resp_result2, resp_flags}, pend_exp);
                        chk("rand_err", resp_err, pend_op == 3'b111);
                        pend = 0;
                        done++;
                    end
                end
            end
            tick();
            n++;
            if (acc) begin
                if (gid) v1 = 0;
                else     v0 = 0;
            end
        end
        chk("rand_done", done, 60);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
